// File: rtl/monkey_input_ctrl.sv
// monkey_input_ctrl
//   Conditions the raw keypad digit and jump key for the monkey movement
//   block. Both inputs are debounced. The direction digit is republished
//   once per frame, aligned to startOfFrame. A jump press becomes a buffered
//   request that lasts a fixed number of frame boundaries.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   startOfFrame    : one-cycle pulse at each frame start
//   keyPad[3:0]     : raw keypad digit code
//   keyIsPressed    : raw key-down level
//   jumpKey         : raw jump key level
//   digitIsPressed  : debounced, frame-aligned key-down
//   digit[3:0]      : debounced, frame-aligned digit (0 when no key is down)
//   jumpIsPressed   : buffered jump request, never high in a startOfFrame cycle

// Debounce channel: a new value is accepted after CYCLES consecutive
// identical samples.
//   i_sample : raw input
//   o_stable : debounced value
module monkey_input_ctrl_debounce #(
  parameter int W      = 1,
  parameter int CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_sample,
  output logic [W-1:0] o_stable
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [W-1:0]  r_cand;
  logic [W-1:0]  r_stable;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // r_cnt holds (number of consecutive identical samples - 1). The first
  // sample of a new value counts as sample 0. The value is accepted on the
  // edge where the count reaches CYCLES-1, so a change first sampled at
  // edge t lands at edge t+CYCLES-1. With CYCLES=1 this is the same edge.
  // The count saturates at CYCLES-1 and never wraps.
  always_comb begin
    w_cnt_nxt = '0;
    if (i_sample == r_cand)
      w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_cand <= i_sample;
      r_cnt  <= w_cnt_nxt;
      if (w_cnt_nxt == CNT_MAX)
        r_stable <= i_sample;
    end
  end

  assign o_stable = r_stable;
endmodule

module monkey_input_ctrl #(
  parameter int DEBOUNCE_CYCLES    = 250000,
  parameter int JUMP_BUFFER_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic [3:0] keyPad,
  input  logic       keyIsPressed,
  input  logic       jumpKey,
  output logic       digitIsPressed,
  output logic [3:0] digit,
  output logic       jumpIsPressed
);
  localparam int FW = $clog2(JUMP_BUFFER_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, BUFFER, LOCKOUT} jump_st_t;

  logic [4:0]    w_key_stable;
  logic          w_jump_stable;
  logic          w_jump_rise;
  logic          r_jump_prev;
  logic [FW-1:0] r_fcnt;
  jump_st_t      r_state;
  logic          r_dig_pressed;
  logic [3:0]    r_digit;

  monkey_input_ctrl_debounce #(.W(5), .CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk      (clk),
    .reset    (reset),
    .i_sample ({keyIsPressed, keyPad}),
    .o_stable (w_key_stable)
  );

  monkey_input_ctrl_debounce #(.W(1), .CYCLES(DEBOUNCE_CYCLES)) u_jump_db (
    .clk      (clk),
    .reset    (reset),
    .i_sample (jumpKey),
    .o_stable (w_jump_stable)
  );

  assign w_jump_rise = w_jump_stable & ~r_jump_prev;

  // Direction is sampled only at frame start so the movement block sees
  // one value for the whole frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dig_pressed <= 1'b0;
      r_digit       <= 4'd0;
    end else if (startOfFrame) begin
      r_dig_pressed <= w_key_stable[4];
      r_digit       <= w_key_stable[4] ? w_key_stable[3:0] : 4'd0;
    end
  end

  // Jump FSM. The entry cycle never decrements, even when it coincides
  // with startOfFrame. Rises seen while in BUFFER are dropped. LOCKOUT
  // forces a release before the next jump.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_fcnt      <= '0;
      r_jump_prev <= 1'b0;
    end else begin
      r_jump_prev <= w_jump_stable;
      case (r_state)
        IDLE: begin
          if (w_jump_rise) begin
            r_state <= BUFFER;
            r_fcnt  <= FW'(JUMP_BUFFER_FRAMES);
          end
        end
        BUFFER: begin
          if (startOfFrame) begin
            if (r_fcnt == FW'(1)) r_state <= LOCKOUT;
            else                  r_fcnt  <= r_fcnt - 1'b1;
          end
        end
        LOCKOUT: begin
          if (!w_jump_stable) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign digitIsPressed = r_dig_pressed;
  assign digit          = r_digit;
  // The request is masked in the frame-start cycle because the movement
  // block clears its jump flag in that cycle.
  assign jumpIsPressed  = (r_state == BUFFER) && !startOfFrame;
endmodule

// File: tb/tb_monkey_input_ctrl.sv
// Directed bench for monkey_input_ctrl. DEBOUNCE_CYCLES=4, JUMP_BUFFER_FRAMES=2,
// startOfFrame high in the cycle after edge N*100. cyc counts posedges.
// Inputs set at cyc c are first sampled at edge c+1, and values read at cyc c
// are those seen after edge c.
module tb_monkey_input_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic [3:0] keyPad;
  logic       keyIsPressed;
  logic       jumpKey;
  logic       digitIsPressed;
  logic [3:0] digit;
  logic       jumpIsPressed;

  int cyc;
  int n_chk;
  int n_fail;

  monkey_input_ctrl #(.DEBOUNCE_CYCLES(4), .JUMP_BUFFER_FRAMES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .keyPad         (keyPad),
    .keyIsPressed   (keyIsPressed),
    .jumpKey        (jumpKey),
    .digitIsPressed (digitIsPressed),
    .digit          (digit),
    .jumpIsPressed  (jumpIsPressed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    startOfFrame = (cyc % 100 == 0);
    #1;
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; keyPad = 4'd0; keyIsPressed = 1'b0;
    jumpKey = 1'b0; cyc = 0; n_chk = 0; n_fail = 0;

    while (cyc < 1105) begin
      tick();
      // checks
      case (cyc)
        2:    begin chk("rst_dip", digitIsPressed, 0); chk("rst_dig", digit, 0);
                    chk("rst_jmp", jumpIsPressed, 0); end
        23:   chk("j3_pre", jumpIsPressed, 0);
        24:   chk("j3_rise", jumpIsPressed, 1);
        99:   begin chk("j3_99", jumpIsPressed, 1); chk("k1_pre", digitIsPressed, 0); end
        100:  begin chk("j3_sof100", jumpIsPressed, 0); chk("k1_sof", digitIsPressed, 0); end
        101:  begin chk("j3_101", jumpIsPressed, 1); chk("k1_dip", digitIsPressed, 1);
                    chk("k1_dig", digit, 6); end
        199:  chk("j3_199", jumpIsPressed, 1);
        200:  begin chk("j3_sof200", jumpIsPressed, 0); chk("k1_hold", digitIsPressed, 1); end
        201:  begin chk("j3_end", jumpIsPressed, 0); chk("k1_rel_dip", digitIsPressed, 0);
                    chk("k1_rel_dig", digit, 0); end
        250:  chk("j3_lockout", jumpIsPressed, 0);
        280:  chk("glitch_stable", dut.u_key_db.r_stable, 0);
        299:  chk("j4_pre", jumpIsPressed, 0);
        300:  chk("j4_sof", jumpIsPressed, 0);
        301:  begin chk("j4_301", jumpIsPressed, 1); chk("glitch_f3", digitIsPressed, 0); end
        400:  chk("j4_sof400", jumpIsPressed, 0);
        401:  begin chk("j4_401", jumpIsPressed, 1); chk("glitch_f4", digitIsPressed, 0); end
        499:  chk("j4_499", jumpIsPressed, 1);
        500:  chk("j4_sof500", jumpIsPressed, 0);
        501:  begin chk("j4_end", jumpIsPressed, 0); chk("glitch_f5", digitIsPressed, 0); end
        600:  chk("k5_pre", digit, 0);
        601:  begin chk("k5_dip", digitIsPressed, 1); chk("k5_dig", digit, 3); end
        614:  chk("j5_buf", jumpIsPressed, 1);
        617:  begin chk("j5_prerst", jumpIsPressed, 1); chk("k5_prerst", digitIsPressed, 1); end
        618:  begin chk("r5_dip", digitIsPressed, 0); chk("r5_dig", digit, 0);
                    chk("r5_jmp", jumpIsPressed, 0); end
        621:  chk("r5_pend_drop", dut.u_key_db.r_stable, 0);
        622:  chk("r5_redeb", dut.u_key_db.r_stable, 5'h17);
        625:  chk("r5_idle", jumpIsPressed, 0);
        700:  chk("r5_dig_hold", digit, 0);
        701:  begin chk("r5_dip_pub", digitIsPressed, 1); chk("r5_dig_pub", digit, 7); end
        714:  chk("j6_buf", jumpIsPressed, 1);
        801:  begin chk("j6_801", jumpIsPressed, 1); chk("k6_rel", digitIsPressed, 0); end
        899:  chk("j6_899", jumpIsPressed, 1);
        900:  chk("j6_sof900", jumpIsPressed, 0);
        901:  chk("j6_noretrig", jumpIsPressed, 0);
        950:  chk("j6_lock", jumpIsPressed, 0);
        964:  chk("j6_pre3", jumpIsPressed, 0);
        965:  chk("j6_third", jumpIsPressed, 1);
        999:  chk("j6_999", jumpIsPressed, 1);
        1000: chk("j6_sof1000", jumpIsPressed, 0);
        1001: chk("j6_1001", jumpIsPressed, 1);
        1099: chk("j6_1099", jumpIsPressed, 1);
        1100: chk("j6_sof1100", jumpIsPressed, 0);
        1101: chk("j6_end", jumpIsPressed, 0);
        default: ;
      endcase
      // drives
      case (cyc)
        2:   reset = 1'b0;
        9:   begin keyIsPressed = 1'b1; keyPad = 4'd6; end
        19:  jumpKey = 1'b1;
        149: begin keyIsPressed = 1'b0; keyPad = 4'd0; end
        259: jumpKey = 1'b0;
        270: begin keyIsPressed = 1'b1; keyPad = 4'd4; end
        273: begin keyIsPressed = 1'b0; keyPad = 4'd0; end
        296: jumpKey = 1'b1;
        509: begin keyIsPressed = 1'b1; keyPad = 4'd3; end
        519: jumpKey = 1'b0;
        609: jumpKey = 1'b1;
        615: keyPad = 4'd7;
        617: begin reset = 1'b1; jumpKey = 1'b0; end
        618: reset = 1'b0;
        705: begin keyIsPressed = 1'b0; keyPad = 4'd0; end
        709: jumpKey = 1'b1;
        810: jumpKey = 1'b0;
        830: jumpKey = 1'b1;
        950: jumpKey = 1'b0;
        960: jumpKey = 1'b1;
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
